// File: rtl/memory_core_pkg.sv
// Shared types and register map for the memory core.
package memory_core_pkg;

    typedef enum logic {
        MODE_LB   = 1'b0,
        MODE_FIFO = 1'b1
    } mode_t;

    localparam logic [7:0] REG_MODE   = 8'h00;
    localparam logic [7:0] REG_DELAY  = 8'h01;
    localparam logic [7:0] REG_AF     = 8'h02;
    localparam logic [7:0] REG_EN     = 8'h03;
    localparam logic [7:0] REG_STATUS = 8'h04;

endpackage

// File: rtl/memory_core_sram_2p.sv
// Two-port buffer: one write port, one synchronous read-first read port.
module sram_2p #(
    parameter  int W     = 16,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Same-address read and write return the old word; both the full
    // line buffer and the full FIFO rely on this.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    o_rdata <= '0;
        else if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/memory_core_param.sv
// Memory core: line buffer or FIFO over a DEPTH x DATA_WIDTH buffer.
// Optional per-word even parity when MEMCORE_PARITY_EN is defined.
module memory_core_param
    import memory_core_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 1024,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic [15:0]           tile_id,
    input  logic                  config_en,
    input  logic [31:0]           config_addr,
    input  logic [31:0]           config_data,
    output logic [31:0]           read_data,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wen_in,
    input  logic                  ren_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  parity_err
);

`ifdef MEMCORE_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    localparam logic [AW:0] L_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_ONE    = (AW+1)'(1);
    localparam logic [AW:0] L_AF_RST = (AW+1)'(DEPTH - 4);

    mode_t         r_mode;
    logic [AW:0]   r_delay, r_af, r_count;
    logic          r_en, r_ovf, r_unf, r_perr, r_valid;
    logic [AW-1:0] r_wptr, r_rptr;
    logic [31:0]   r_rd;

    logic          w_cfg_wr, w_act, w_lb, w_push, w_pop, w_lb_rd, w_rd_en, w_perr_now;
    logic [AW-1:0] w_raddr;
    logic [MW-1:0] w_wdata, w_rdata;
    logic [31:0]   w_status;
    logic          w_unused_bits;

    assign w_unused_bits = ^config_addr[23:16];

    assign w_cfg_wr = config_en && (config_addr[15:0] == tile_id);
    assign w_act    = r_en && !w_cfg_wr;
    assign w_lb     = (r_mode == MODE_LB);

    assign empty       = (r_count == '0);
    assign full        = !w_lb && (r_count == L_DEPTH);
    assign almost_full = !w_lb && (r_count >= r_af);

    assign w_pop   = w_act && !w_lb && ren_in && !empty;
    assign w_push  = w_act && wen_in && (w_lb || !full || w_pop);
    // Line buffer emits the word written delay writes ago once primed.
    assign w_lb_rd = w_act && w_lb && wen_in && (r_count == r_delay);
    assign w_rd_en = w_pop || w_lb_rd;
    assign w_raddr = w_lb ? (r_wptr - r_delay[AW-1:0]) : r_rptr;

`ifdef MEMCORE_PARITY_EN
    assign w_wdata    = {^data_in, data_in};
    assign w_perr_now = r_valid && (^w_rdata);
`else
    assign w_wdata    = data_in;
    assign w_perr_now = 1'b0;
`endif

    sram_2p #(.W(MW), .DEPTH(DEPTH)) u_sram (
        .clk     (clk_in),
        .rst_n   (reset_n),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_re    (w_rd_en),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign data_out   = w_rdata[DATA_WIDTH-1:0];
    assign valid_out  = r_valid;
    assign parity_err = r_perr;
    assign read_data  = r_rd;

    always_comb begin
        w_status           = '0;
        w_status[31]       = r_perr;
        w_status[AW+2:0]   = {r_ovf, r_unf, r_count};
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_mode  <= MODE_LB;
            r_delay <= L_ONE;
            r_af    <= L_AF_RST;
            r_en    <= 1'b0;
        end else if (w_cfg_wr) begin
            case (config_addr[31:24])
                REG_MODE:  r_mode <= (config_data == 32'd1) ? MODE_FIFO : MODE_LB;
                REG_DELAY: begin
                    if (config_data == '0)         r_delay <= L_ONE;
                    else if (config_data > DEPTH)  r_delay <= L_DEPTH;
                    else                           r_delay <= config_data[AW:0];
                end
                REG_AF:    r_af <= config_data[AW:0];
                REG_EN:    r_en <= config_data[0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_perr  <= 1'b0;
        end else if (w_cfg_wr) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_valid <= w_rd_en;
            r_perr  <= r_perr | w_perr_now;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_lb) begin
                if (w_push && (r_count != r_delay)) r_count <= r_count + L_ONE;
            end else begin
                if (w_push && !w_pop)      r_count <= r_count + L_ONE;
                else if (w_pop && !w_push) r_count <= r_count - L_ONE;
                if (w_act && wen_in && !w_push) r_ovf <= 1'b1;
                if (w_act && ren_in && empty)   r_unf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) r_rd <= '0;
        else begin
            case (config_addr[31:24])
                REG_MODE:   r_rd <= 32'(r_mode);
                REG_DELAY:  r_rd <= 32'(r_delay);
                REG_AF:     r_rd <= 32'(r_af);
                REG_EN:     r_rd <= 32'(r_en);
                REG_STATUS: r_rd <= w_status;
                default:    r_rd <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_core_param.sv
// Scoreboard bench: a small (DEPTH=4) core for streaming and a DEPTH=1024
// core sharing the same inputs for configuration clamping checks.
module tb_memory_core_param;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic [15:0] tile_id = 16'h0012;
    logic        config_en;
    logic [31:0] config_addr, config_data;
    logic [15:0] data_in;
    logic        wen_in, ren_in;

    logic [31:0] s_rd, b_rd;
    logic [15:0] s_dout, b_dout;
    logic        s_vld, s_full, s_empty, s_af, s_perr;
    logic        b_vld, b_full, b_empty, b_af, b_perr;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    always #5 clk_in = ~clk_in;

    memory_core_param #(.DATA_WIDTH(16), .DEPTH(4)) u_dut (
        .clk_in(clk_in), .reset_n(reset_n), .tile_id(tile_id),
        .config_en(config_en), .config_addr(config_addr), .config_data(config_data),
        .read_data(s_rd), .data_in(data_in), .wen_in(wen_in), .ren_in(ren_in),
        .data_out(s_dout), .valid_out(s_vld), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .parity_err(s_perr)
    );

    memory_core_param #(.DATA_WIDTH(16), .DEPTH(1024)) u_big (
        .clk_in(clk_in), .reset_n(reset_n), .tile_id(tile_id),
        .config_en(config_en), .config_addr(config_addr), .config_data(config_data),
        .read_data(b_rd), .data_in(data_in), .wen_in(wen_in), .ren_in(ren_in),
        .data_out(b_dout), .valid_out(b_vld), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .parity_err(b_perr)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cfg(input logic [7:0] idx, input logic [15:0] tid, input logic [31:0] d);
        config_en   = 1'b1;
        config_addr = {idx, 8'h00, tid};
        config_data = d;
        step();
        config_en   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] idx);
        config_addr = {idx, 8'h00, tile_id};
        step();
    endtask

    // One stream cycle; expected output (if any) is queued after the edge
    // that accepts the operation, so an early output is caught as unexpected.
    task automatic op(input logic w, input logic r, input logic [15:0] d,
                      input logic has_exp, input logic [15:0] e);
        wen_in  = w;
        ren_in  = r;
        data_in = d;
        step();
        wen_in  = 1'b0;
        ren_in  = 1'b0;
        if (has_exp) exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        repeat (2) step();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk_in) begin
        if (reset_n === 1'b1 && s_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got %0d, required no valid_out", s_dout);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("stream_data", 32'(s_dout), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; config_en = 1'b0; config_addr = '0; config_data = '0;
        data_in = '0; wen_in = 1'b0; ren_in = 1'b0;
        repeat (3) step();
        chk("rst_empty", 32'(s_empty), 32'd1);
        chk("rst_valid", 32'(s_vld), 32'd0);
        chk("rst_read_data", s_rd, 32'd0);
        chk("rst_full_af_perr", {29'd0, s_full, s_af, s_perr}, 32'd0);
        reset_n = 1'b1;
        rd(8'h01);
        chk("rst_delay", s_rd, 32'd1);
        rd(8'h02);
        chk("rst_af_big", b_rd, 32'd1020);
        chk("rst_af_small", s_rd, 32'd0);

        // Line buffer, delay 3
        cfg(8'h03, tile_id, 32'd1);
        cfg(8'h01, tile_id, 32'd3);
        op(1, 0, 16'd1, 0, 0);
        op(1, 0, 16'd2, 0, 0);
        op(1, 0, 16'd3, 0, 0);
        op(1, 0, 16'd4, 1, 16'd1);
        op(1, 0, 16'd5, 1, 16'd2);
        chk("lb_full_af_held", {30'd0, s_full, s_af}, 32'd0);
        drain("lb_drain");
        rd(8'h04);
        chk("lb_status_count", s_rd, 32'd3);

        // FIFO, af_thresh 3
        cfg(8'h00, tile_id, 32'd1);
        cfg(8'h02, tile_id, 32'd3);
        op(1, 0, 16'd10, 0, 0);
        op(1, 0, 16'd11, 0, 0);
        op(1, 0, 16'd12, 0, 0);
        chk("fifo_af_at3", {30'd0, s_full, s_af}, 32'd1);
        op(1, 0, 16'd13, 0, 0);
        chk("fifo_full", {29'd0, s_full, s_af, s_empty}, 32'b110);
        op(1, 1, 16'd99, 1, 16'd10);
        rd(8'h04);
        chk("fifo_pushpop_status", s_rd, 32'h04);
        op(1, 0, 16'd14, 0, 0);
        rd(8'h04);
        chk("fifo_overflow_status", s_rd, 32'h14);
        op(0, 1, 0, 1, 16'd11);
        op(0, 1, 0, 1, 16'd12);
        op(0, 1, 0, 1, 16'd13);
        op(0, 1, 0, 1, 16'd99);
        chk("fifo_empty_after_pops", 32'(s_empty), 32'd1);
        op(0, 1, 0, 0, 0);
        drain("fifo_drain");
        rd(8'h04);
        chk("fifo_underflow_status", s_rd, 32'h18);
        op(1, 1, 16'd7, 0, 0);
        rd(8'h04);
        chk("fifo_push_pop_on_empty", s_rd, 32'h19);

        // Configuration clamps and tile matching
        cfg(8'h01, tile_id, 32'd2000);
        rd(8'h01);
        chk("delay_clamp_big", b_rd, 32'd1024);
        chk("delay_clamp_small", s_rd, 32'd4);
        cfg(8'h01, tile_id, 32'd0);
        rd(8'h01);
        chk("delay_zero", s_rd, 32'd1);
        cfg(8'h00, tile_id, 32'd5);
        rd(8'h00);
        chk("mode_invalid", s_rd, 32'd0);
        cfg(8'h00, 16'h0013, 32'd1);
        rd(8'h00);
        chk("mode_other_tile", s_rd, 32'd0);

        // Mid-stream flush discards the concurrent push
        cfg(8'h00, tile_id, 32'd1);
        op(1, 0, 16'd21, 0, 0);
        op(1, 0, 16'd22, 0, 0);
        rd(8'h04);
        chk("mid_count", s_rd, 32'd2);
        wen_in = 1'b1; data_in = 16'd23;
        cfg(8'h02, tile_id, 32'd3);
        wen_in = 1'b0;
        chk("flush_empty", 32'(s_empty), 32'd1);
        rd(8'h04);
        chk("flush_status", s_rd, 32'd0);

        // Disabled core ignores stream ops
        cfg(8'h03, tile_id, 32'd0);
        op(1, 0, 16'd30, 0, 0);
        chk("disabled_empty", 32'(s_empty), 32'd1);
        chk("parity_off", {31'd0, s_perr}, 32'd0);
        drain("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_core_param.md
# memory_core_param

Parametrised memory core for the CGRA memory tile. Holds a DEPTH x DATA_WIDTH two-port buffer and runs it as either a fixed-delay line buffer or a FIFO, selected at runtime through the tile's address/data configuration bus, with a configuration readback port. It sits inside the memory tile between the routed 16-bit bus inputs and outputs and the global configuration chain. It generalises the single-mode tile with parametric width and depth, a mode register and FIFO flow control.

## Interface
- DATA_WIDTH, 16, data word width
- DEPTH, 1024, buffer words; power of two, at least 4
- AW, $clog2(DEPTH), derived pointer width; not overridable
- clk_in  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- tile_id  input  16  this tile's configuration address
- config_en  input  1  configuration write strobe
- config_addr  input  32  [15:0] tile match, [31:24] register index
- config_data  input  32  write data
- read_data  output  32  registered readback of the addressed register
- data_in  input  DATA_WIDTH  stream input
- wen_in  input  1  push request
- ren_in  input  1  pop request; FIFO mode only
- data_out  output  DATA_WIDTH  registered output word
- valid_out  output  1  data_out qualifier, one cycle per word
- full, empty, almost_full  output  1 each  occupancy flags
- parity_err  output  1  sticky parity error (see Configuration)

## Operation
- Register writes occur when config_en=1 and config_addr[15:0]==tile_id.
- Register map:
  - 0x00 mode: 0 = line buffer, 1 = FIFO; other values are stored as 0.
  - 0x01 delay, AW+1 bits: written 0 stores as 1; values above DEPTH store as DEPTH.
  - 0x02 af_thresh, AW+1 bits.
  - 0x03 enable, bit 0.
  - 0x04 status, read-only: {overflow, underflow, count}.
- Every accepted register write flushes the buffer. Flush clears count, both pointers, valid_out, overflow and underflow.
- While enable=0, wen_in and ren_in are ignored.
- Line-buffer mode:
  - Each wen_in writes data_in.
  - count increments per write and saturates at delay.
  - When a write arrives with count==delay, the word written delay writes earlier is read out. data_out/valid_out present it one cycle after that write.
  - ren_in is ignored. full and almost_full are held 0.
- FIFO mode:
  - A push is accepted when !full, or when full with a pop accepted in the same cycle.
  - A pop is accepted when !empty. Pop with push on empty: the push is accepted and the pop is rejected.
  - A rejected push sets overflow; a rejected pop sets underflow. Both are sticky until flush or reset.
  - Popped word appears on data_out with valid_out=1 one cycle after the pop.
- Flags: empty = (count==0); full = (count==DEPTH) in FIFO mode; almost_full = (count>=af_thresh) in FIFO mode. All derive from registered count.
- Pointers wrap modulo DEPTH. Count arithmetic is AW+1 bits wide and never wraps.

## Timing
- Reset values:
  - data_out=0, valid_out=0, read_data=0, full=0, empty=1, almost_full=0, parity_err=0.
  - mode=0, delay=1, af_thresh=DEPTH-4, enable=0.
- Config writes take effect on the next edge. Stream ops in the same cycle as a write are discarded (flush wins).
- read_data is valid one cycle after config_addr selects a register. It updates every cycle regardless of config_en.
- Push-to-output latency: line buffer = delay writes + 1 cycle; FIFO pop-to-output = 1 cycle.
- Flags reflect the state after the previous edge's operations.
- Reset asserted mid-stream returns all state to the reset values immediately. Buffer contents are undefined afterwards.

## Configuration
- MEMCORE_PARITY_EN defined:
  - Each stored word carries one even-parity bit.
  - A mismatch on any read sets parity_err. It is sticky until reset or flush, and is also visible in status bit 31.
- MEMCORE_PARITY_EN undefined: no parity storage; parity_err and status bit 31 are tied to 0.

## Structure
- Package memory_core_pkg holds:
  - mode_t enum (MODE_LB, MODE_FIFO);
  - register index constants REG_MODE, REG_DELAY, REG_AF, REG_EN, REG_STATUS.
- Sub-module sram_2p: one write port and one synchronous read port, DEPTH x (DATA_WIDTH + parity bit when enabled).

## Test plan
- Reset with no config → empty=1, valid_out=0, read_data=0; reg 0x01 reads 1.
- Line buffer, delay=3, enable=1, push 1,2,3,4,5 on consecutive cycles → valid_out first rises the cycle after the push of 4 with data_out=1, then data_out=2; no output earlier.
- FIFO, DEPTH=4, af_thresh=3: push 10,11,12,13 → full=1 and almost_full=1. Fifth push → rejected, overflow=1. Pops → 10,11,12,13, each one cycle after its pop.
- FIFO full with simultaneous push 99 and pop → count stays 4, overflow stays 0, and 99 is the last word popped.
- Write delay=2000 with DEPTH=1024 → reads back 1024. Write mode=5 → reads back 0. Config write mid-stream → count=0, empty=1.
- With MEMCORE_PARITY_EN, force a stored bit flip, then pop → parity_err=1, status bit 31=1. A later reset clears both.
